// File: rtl/func_sequencer_pkg.sv
// Shared encodings for the function sequencer: FSM states and the
// selection-index to LED-decoder code mapping.
package func_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_EXEC   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [2:0] FUNC_OFF = 3'd0;
    localparam logic [2:0] FUNC_1   = 3'd1;
    localparam logic [2:0] FUNC_3   = 3'd3;
    localparam logic [2:0] FUNC_4   = 3'd4;
    localparam logic [2:0] FUNC_6   = 3'd6;

    localparam logic [3:0][2:0] SEL_CODE = {FUNC_6, FUNC_4, FUNC_3, FUNC_1};

    function automatic logic [2:0] sel_to_code(input logic [1:0] sel);
        return SEL_CODE[sel];
    endfunction

endpackage

// File: rtl/func_sequencer_btn_edge.sv
// Rising-edge detector for one debounced button. History resets to 1 so a
// button held through reset release is not seen as a press.
module btn_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    logic hist_q;
    logic hist_d;

    always_comb begin
        hist_d = btn;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) hist_q <= 1'b1;
        else        hist_q <= hist_d;
    end

    assign rise = btn & ~hist_q;

endmodule

// File: rtl/func_sequencer.sv
// Button-driven function selector: blinking preview, timed execution with
// busy/done handshake, registered 3-bit code to the LED decoder.
module func_sequencer
    import func_sequencer_pkg::*;
#(
    parameter int HOLD_CYCLES  = 8,
    parameter int BLINK_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_confirm,
    input  logic       btn_cancel,
    output logic [2:0] func,
    output logic       busy,
    output logic       exec_start,
    output logic       done
);

    localparam int HW = $clog2(HOLD_CYCLES);
    localparam int BW = $clog2(BLINK_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    logic next_ev, prev_ev, confirm_ev, cancel_ev;

    btn_edge_detect u_next    (.clk(clk), .rst_n(rst_n), .btn(btn_next),    .rise(next_ev));
    btn_edge_detect u_prev    (.clk(clk), .rst_n(rst_n), .btn(btn_prev),    .rise(prev_ev));
    btn_edge_detect u_confirm (.clk(clk), .rst_n(rst_n), .btn(btn_confirm), .rise(confirm_ev));
    btn_edge_detect u_cancel  (.clk(clk), .rst_n(rst_n), .btn(btn_cancel),  .rise(cancel_ev));

    state_e        state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [2:0]    func_q, func_d;
    logic          busy_q, busy_d;
    logic          exec_start_q, exec_start_d;
    logic          done_q, done_d;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        hold_cnt_d  = hold_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (!cancel_ev && (next_ev || prev_ev)) begin
                    state_d     = ST_SELECT;
                    blink_cnt_d = '0;
                    phase_d     = 1'b1;
                end
            end
            ST_SELECT: begin
                if (cancel_ev) begin
                    state_d = ST_IDLE;
                end else if (confirm_ev) begin
                    state_d    = ST_EXEC;
                    hold_cnt_d = '0;
                end else if (next_ev ^ prev_ev) begin
                    sel_d       = next_ev ? sel_q + 2'd1 : sel_q - 2'd1;
                    blink_cnt_d = '0;
                    phase_d     = 1'b1;
                end else if (blink_cnt_q == BLINK_LAST) begin
                    blink_cnt_d = '0;
                    phase_d     = ~phase_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + BW'(1);
                end
            end
            ST_EXEC: begin
                if (cancel_ev)                     state_d = ST_IDLE;
                else if (hold_cnt_q == HOLD_LAST)  state_d = ST_DONE;
                else                               hold_cnt_d = hold_cnt_q + HW'(1);
            end
            ST_DONE: begin
                state_d     = ST_SELECT;
                blink_cnt_d = '0;
                phase_d     = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered, so they are derived from the next state.
        func_d       = FUNC_OFF;
        busy_d       = 1'b0;
        exec_start_d = 1'b0;
        done_d       = 1'b0;
        case (state_d)
            ST_SELECT: func_d = phase_d ? sel_to_code(sel_d) : FUNC_OFF;
            ST_EXEC: begin
                func_d       = sel_to_code(sel_d);
                busy_d       = 1'b1;
                exec_start_d = (state_q != ST_EXEC);
            end
            ST_DONE: begin
                func_d = sel_to_code(sel_d);
                done_d = 1'b1;
            end
            default: func_d = FUNC_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sel_q        <= 2'd0;
            blink_cnt_q  <= '0;
            phase_q      <= 1'b0;
            hold_cnt_q   <= '0;
            func_q       <= FUNC_OFF;
            busy_q       <= 1'b0;
            exec_start_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            blink_cnt_q  <= blink_cnt_d;
            phase_q      <= phase_d;
            hold_cnt_q   <= hold_cnt_d;
            func_q       <= func_d;
            busy_q       <= busy_d;
            exec_start_q <= exec_start_d;
            done_q       <= done_d;
        end
    end

    assign func       = func_q;
    assign busy       = busy_q;
    assign exec_start = exec_start_q;
    assign done       = done_q;

endmodule

// File: tb/tb_func_sequencer.sv
// Directed-vector bench for func_sequencer: each step pushes the expected
// post-edge outputs; a monitor pops and compares one entry per clock.
module tb_func_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_next, btn_prev, btn_confirm, btn_cancel;
    logic [2:0] func;
    logic       busy, exec_start, done;

    func_sequencer #(.HOLD_CYCLES(8), .BLINK_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_next(btn_next), .btn_prev(btn_prev),
        .btn_confirm(btn_confirm), .btn_cancel(btn_cancel),
        .func(func), .busy(busy), .exec_start(exec_start), .done(done)
    );

    always #5 clk = ~clk;

    logic [5:0] exp_q[$];
    string      name_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    // b = {cancel, confirm, prev, next}; expectation is for the outputs after the next edge
    task automatic step(input string nm, input logic r, input logic [3:0] b,
                        input logic [2:0] f, input logic bz, input logic es, input logic dn);
        @(negedge clk);
        rst_n       = r;
        btn_cancel  = b[3];
        btn_confirm = b[2];
        btn_prev    = b[1];
        btn_next    = b[0];
        exp_q.push_back({f, bz, es, dn});
        name_q.push_back(nm);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [5:0] e;
            logic [5:0] a;
            string      nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {func, busy, exec_start, done};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s: got func=%0d busy=%b start=%b done=%b, want func=%0d busy=%b start=%b done=%b",
                         nm, a[5:3], a[2], a[1], a[0], e[5:3], e[2], e[1], e[0]);
            end
        end
    end

    initial begin
        rst_n = 1'b0; btn_next = 1'b0; btn_prev = 1'b0; btn_confirm = 1'b0; btn_cancel = 1'b0;

        // reset with next held, then keep it held: no edge
        for (int i = 0; i < 2; i++) step("reset", 0, 4'b0001, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step("held_next_idle", 1, 4'b0001, 0, 0, 0, 0);
        step("next_drop", 1, 4'b0000, 0, 0, 0, 0);
        step("enter_select", 1, 4'b0001, 1, 0, 0, 0);
        step("sel0_hold", 1, 4'b0000, 1, 0, 0, 0);

        // ring walk with wrap, then prev
        step("next_3", 1, 4'b0001, 3, 0, 0, 0);
        step("hold_3", 1, 4'b0000, 3, 0, 0, 0);
        step("next_4", 1, 4'b0001, 4, 0, 0, 0);
        step("hold_4", 1, 4'b0000, 4, 0, 0, 0);
        step("next_6", 1, 4'b0001, 6, 0, 0, 0);
        step("hold_6", 1, 4'b0000, 6, 0, 0, 0);
        step("next_wrap_1", 1, 4'b0001, 1, 0, 0, 0);
        step("hold_1", 1, 4'b0000, 1, 0, 0, 0);
        step("prev_wrap_6", 1, 4'b0010, 6, 0, 0, 0);

        // blink: 6,6,0,0,6,6,0 counting the prev edge
        step("blink_a", 1, 4'b0000, 6, 0, 0, 0);
        step("blink_b", 1, 4'b0000, 0, 0, 0, 0);
        step("blink_c", 1, 4'b0000, 0, 0, 0, 0);
        step("blink_d", 1, 4'b0000, 6, 0, 0, 0);
        step("blink_e", 1, 4'b0000, 6, 0, 0, 0);
        step("blink_f", 1, 4'b0000, 0, 0, 0, 0);

        // select code 4 and run the full hold
        step("prev_4", 1, 4'b0010, 4, 0, 0, 0);
        step("hold_4b", 1, 4'b0000, 4, 0, 0, 0);
        step("exec_start", 1, 4'b0100, 4, 1, 1, 0);
        for (int i = 0; i < 7; i++) step("exec_busy", 1, 4'b0000, 4, 1, 0, 0);
        step("done_pulse", 1, 4'b0000, 4, 0, 0, 1);
        step("post_done_select", 1, 4'b0000, 4, 0, 0, 0);
        step("post_done_blink", 1, 4'b0000, 4, 0, 0, 0);

        // cancel at EXEC cycle 3
        step("exec2_start", 1, 4'b0100, 4, 1, 1, 0);
        step("exec2_c2", 1, 4'b0000, 4, 1, 0, 0);
        step("exec2_c3", 1, 4'b0000, 4, 1, 0, 0);
        step("exec_cancel", 1, 4'b1000, 0, 0, 0, 0);
        step("cancel_idle_a", 1, 4'b0000, 0, 0, 0, 0);
        step("cancel_idle_b", 1, 4'b0000, 0, 0, 0, 0);
        step("sel_retained", 1, 4'b0001, 4, 0, 0, 0);
        step("sel_retained_hold", 1, 4'b0000, 4, 0, 0, 0);

        // simultaneous events
        step("next_prev_same", 1, 4'b0011, 0, 0, 0, 0);
        step("np_blink_a", 1, 4'b0000, 0, 0, 0, 0);
        step("np_blink_b", 1, 4'b0000, 4, 0, 0, 0);
        step("confirm_next", 1, 4'b0101, 4, 1, 1, 0);
        step("cn_exec2", 1, 4'b0000, 4, 1, 0, 0);
        step("cn_cancel", 1, 4'b1000, 0, 0, 0, 0);
        step("cn_idle", 1, 4'b0000, 0, 0, 0, 0);
        step("reselect", 1, 4'b0001, 4, 0, 0, 0);
        step("reselect_hold", 1, 4'b0000, 4, 0, 0, 0);
        step("cancel_confirm", 1, 4'b1100, 0, 0, 0, 0);
        step("cc_idle", 1, 4'b0000, 0, 0, 0, 0);

        // reset in the middle of EXEC
        step("rs_select", 1, 4'b0001, 4, 0, 0, 0);
        step("rs_hold", 1, 4'b0000, 4, 0, 0, 0);
        step("rs_exec", 1, 4'b0100, 4, 1, 1, 0);
        step("rs_exec2", 1, 4'b0000, 4, 1, 0, 0);
        step("mid_reset", 0, 4'b0000, 0, 0, 0, 0);
        step("after_reset", 1, 4'b0000, 0, 0, 0, 0);
        step("after_reset_b", 1, 4'b0000, 0, 0, 0, 0);
        step("after_reset_sel0", 1, 4'b0001, 1, 0, 0, 0);
        step("after_reset_hold", 1, 4'b0000, 1, 0, 0, 0);

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
